// File: rtl/h14tx_timings_frame.sv
// ============================================================================
// Module   : h14tx_timings_frame
// Brief    : HDMI 1.4 frame timing generator with data-island scheduling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package h14tx_pkg;
  typedef enum logic [2:0] {
    Control            = 3'd0,
    VideoActive        = 3'd1,
    VideoPreamble      = 3'd2,
    VideoGuard         = 3'd3,
    DataIslandPreamble = 3'd4,
    DataIslandGuard    = 3'd5,
    DataIslandActive   = 3'd6
  } period_t;
endpackage

module h14tx_timings_frame
  import h14tx_pkg::*;
#(
  parameter int   BitWidth         = 11,
  parameter int   BitHeight        = 10,
  parameter int   FrameWidth       = 1650,
  parameter int   FrameHeight      = 750,
  parameter int   ActiveWidth      = 1280,
  parameter int   ActiveHeight     = 720,
  parameter int   HSyncStart       = 1390,
  parameter int   HSyncWidth       = 40,
  parameter int   VSyncStart       = 725,
  parameter int   VSyncWidth       = 5,
  parameter logic SyncActiveHigh   = 1'b1,
  parameter int   IslandStart      = ActiveWidth + 12,
  parameter int   MaxIslandPackets = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dvi_mode,
  input  logic                 packet_valid,
  output logic [BitWidth-1:0]  x,
  output logic [BitHeight-1:0] y,
  output period_t              timings,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 packet_ready,
  output logic [4:0]           packet_cycle,
  output logic [4:0]           packet_index
);

  // Packets that fit between the island start and the trailing guard,
  // control gap and video preamble at the end of the line.
  localparam int c_fitPackets = (FrameWidth - 22 - IslandStart - 12) / 32;
  localparam int MaxPackets   = (c_fitPackets < MaxIslandPackets) ? c_fitPackets : MaxIslandPackets;

  if (MaxPackets < 1 || IslandStart < ActiveWidth + 4) begin : g_paramCheck
    $fatal(1, "h14tx_timings_frame: data island does not fit in horizontal blanking");
  end

  localparam logic [BitWidth-1:0]  c_xLast       = BitWidth'(FrameWidth - 1);
  localparam logic [BitHeight-1:0] c_yLast       = BitHeight'(FrameHeight - 1);
  localparam logic [BitWidth-1:0]  c_activeW     = BitWidth'(ActiveWidth);
  localparam logic [BitHeight-1:0] c_activeH     = BitHeight'(ActiveHeight);
  localparam logic [BitHeight-1:0] c_guardLineLim = BitHeight'(ActiveHeight - 1);
  localparam logic [BitWidth-1:0]  c_vPreX       = BitWidth'(FrameWidth - 10);
  localparam logic [BitWidth-1:0]  c_vGuardX     = BitWidth'(FrameWidth - 2);
  localparam logic [BitWidth-1:0]  c_hsStart     = BitWidth'(HSyncStart);
  localparam logic [BitWidth-1:0]  c_hsEnd       = BitWidth'(HSyncStart + HSyncWidth);
  localparam logic [BitHeight-1:0] c_vsStart     = BitHeight'(VSyncStart);
  localparam logic [BitHeight-1:0] c_vsEnd       = BitHeight'(VSyncStart + VSyncWidth);
  localparam logic [BitWidth-1:0]  c_islandStart = BitWidth'(IslandStart);
  localparam logic [4:0]           c_lastPacket  = 5'(MaxPackets - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    DI_PREAMBLE    = 3'd1,
    DI_LEAD_GUARD  = 3'd2,
    DI_ACTIVE      = 3'd3,
    DI_TRAIL_GUARD = 3'd4
  } islandState_t;

  logic [BitWidth-1:0]  r_x,  w_xNext;
  logic [BitHeight-1:0] r_y,  w_yNext;
  period_t              r_timings, w_timingsNext;
  logic                 r_hsync, r_vsync, r_frameStart, r_packetReady, r_dvi;
  logic                 w_dviNext, w_readyNext, w_guardLine;
  logic [4:0]           r_packetCycle, w_cycleNext;
  logic [4:0]           r_packetIndex, w_indexNext;
  logic [2:0]           r_phaseCnt, w_phaseNext;
  islandState_t         r_state, w_stateNext;

  // Everything below is computed for the position the counters move to, so
  // every register updated on the same edge describes the same pixel.
  always_comb begin
    w_xNext = (r_x == c_xLast) ? '0 : r_x + 1'b1;
    w_yNext = r_y;
    if (r_x == c_xLast) begin
      w_yNext = (r_y == c_yLast) ? '0 : r_y + 1'b1;
    end
    w_dviNext = (w_xNext == '0 && w_yNext == '0) ? dvi_mode : r_dvi;
  end

  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = r_phaseCnt;
    w_cycleNext = '0;
    w_indexNext = r_packetIndex;
    w_readyNext = 1'b0;
    case (r_state)
      IDLE: begin
        w_indexNext = '0;
        if (!w_dviNext && packet_valid && w_xNext == c_islandStart) begin
          w_stateNext = DI_PREAMBLE;
          w_phaseNext = '0;
        end
      end
      DI_PREAMBLE: begin
        if (r_phaseCnt == 3'd7) begin
          w_stateNext = DI_LEAD_GUARD;
          w_phaseNext = '0;
        end else begin
          w_phaseNext = r_phaseCnt + 3'd1;
        end
      end
      DI_LEAD_GUARD: begin
        if (r_phaseCnt == 3'd1) begin
          w_stateNext = DI_ACTIVE;
          w_indexNext = '0;
          w_readyNext = 1'b1;
        end else begin
          w_phaseNext = r_phaseCnt + 3'd1;
        end
      end
      DI_ACTIVE: begin
        if (r_packetCycle == 5'd31) begin
          if (packet_valid && r_packetIndex < c_lastPacket) begin
            w_indexNext = r_packetIndex + 5'd1;
            w_readyNext = 1'b1;
          end else begin
            w_stateNext = DI_TRAIL_GUARD;
            w_phaseNext = '0;
          end
        end else begin
          w_cycleNext = r_packetCycle + 5'd1;
        end
      end
      DI_TRAIL_GUARD: begin
        if (r_phaseCnt == 3'd1) begin
          w_stateNext = IDLE;
        end else begin
          w_phaseNext = r_phaseCnt + 3'd1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_guardLine   = (w_yNext < c_guardLineLim) || (w_yNext == c_yLast);
    w_timingsNext = Control;
    if (w_stateNext == DI_PREAMBLE) begin
      w_timingsNext = DataIslandPreamble;
    end else if (w_stateNext == DI_LEAD_GUARD || w_stateNext == DI_TRAIL_GUARD) begin
      w_timingsNext = DataIslandGuard;
    end else if (w_stateNext == DI_ACTIVE) begin
      w_timingsNext = DataIslandActive;
    end else if (w_xNext < c_activeW && w_yNext < c_activeH) begin
      w_timingsNext = VideoActive;
    end else if (!w_dviNext && w_guardLine && w_xNext >= c_vGuardX) begin
      w_timingsNext = VideoGuard;
    end else if (!w_dviNext && w_guardLine && w_xNext >= c_vPreX) begin
      w_timingsNext = VideoPreamble;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x           <= c_xLast;
      r_y           <= c_yLast;
      r_timings     <= Control;
      r_hsync       <= ~SyncActiveHigh;
      r_vsync       <= ~SyncActiveHigh;
      r_frameStart  <= 1'b0;
      r_packetReady <= 1'b0;
      r_packetCycle <= '0;
      r_packetIndex <= '0;
      r_phaseCnt    <= '0;
      r_state       <= IDLE;
      r_dvi         <= 1'b0;
    end else begin
      r_x           <= w_xNext;
      r_y           <= w_yNext;
      r_timings     <= w_timingsNext;
      r_hsync       <= (w_xNext >= c_hsStart && w_xNext < c_hsEnd) ? SyncActiveHigh : ~SyncActiveHigh;
      r_vsync       <= (w_yNext >= c_vsStart && w_yNext < c_vsEnd) ? SyncActiveHigh : ~SyncActiveHigh;
      r_frameStart  <= (w_xNext == '0) && (w_yNext == '0);
      r_packetReady <= w_readyNext;
      r_packetCycle <= w_cycleNext;
      r_packetIndex <= w_indexNext;
      r_phaseCnt    <= w_phaseNext;
      r_state       <= w_stateNext;
      r_dvi         <= w_dviNext;
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign timings      = r_timings;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign frame_start  = r_frameStart;
  assign packet_ready = r_packetReady;
  assign packet_cycle = r_packetCycle;
  assign packet_index = r_packetIndex;

endmodule

`default_nettype wire

// File: tb/tb_h14tx_timings_frame.sv
// ============================================================================
// Module   : tb_h14tx_timings_frame
// Brief    : Directed bench for h14tx_timings_frame on a reduced geometry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_h14tx_timings_frame;
  import h14tx_pkg::*;

  // 160x12 frame, 40x8 active, island at x=52, two packets fit per island.
  localparam int FW = 160;
  localparam int FH = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dvi_mode = 1'b0;
  logic       packet_valid = 1'b0;
  logic [7:0] x;
  logic [3:0] y;
  period_t    timings;
  logic       hsync, vsync, frame_start, packet_ready;
  logic [4:0] packet_cycle, packet_index;

  h14tx_timings_frame #(
    .BitWidth(8), .BitHeight(4), .FrameWidth(FW), .FrameHeight(FH),
    .ActiveWidth(40), .ActiveHeight(8), .HSyncStart(135), .HSyncWidth(8),
    .VSyncStart(9), .VSyncWidth(2), .SyncActiveHigh(1'b1),
    .IslandStart(52), .MaxIslandPackets(18)
  ) dut (
    .clk(clk), .rst(rst), .dvi_mode(dvi_mode), .packet_valid(packet_valid),
    .x(x), .y(y), .timings(timings), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .packet_ready(packet_ready),
    .packet_cycle(packet_cycle), .packet_index(packet_index)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  period_t tm  [FW];
  logic    rdy [FW];
  int      pcA [FW];
  int      piA [FW];

  int fActive, fVPre, fVGuard, fIsland, fReady, fHs, fVs, fFs;
  int hsMin, hsMax, vsMinY, vsMaxY, vsBadEdge;

  task automatic chk(input string name, input int obs, input int exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit isIsland(input period_t p);
    return p == DataIslandPreamble || p == DataIslandGuard || p == DataIslandActive;
  endfunction

  function automatic int countRange(input int lo, input int hi, input period_t p);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (tm[k] == p) n++;
    return n;
  endfunction

  function automatic int islandCount();
    int n = 0;
    for (int k = 0; k < FW; k++) if (isIsland(tm[k])) n++;
    return n;
  endfunction

  function automatic int readyCount();
    int n = 0;
    for (int k = 0; k < FW; k++) if (rdy[k]) n++;
    return n;
  endfunction

  task automatic waitPos(input int wx, input int wy, input string name);
    bit found = 0;
    for (int i = 0; i < 4 * FW * FH; i++) begin
      if (int'(x) == wx && int'(y) == wy) begin
        found = 1;
        break;
      end
      tick();
    end
    chk(name, int'(found), 1);
  endtask

  // Record one line starting at x=0; optional mid-line stimulus changes.
  task automatic recLine(input bit dropOnReady, input int raiseAt);
    for (int k = 0; k < FW; k++) begin
      tm[k]  = timings;
      rdy[k] = packet_ready;
      pcA[k] = int'(packet_cycle);
      piA[k] = int'(packet_index);
      if (dropOnReady && packet_ready) packet_valid = 1'b0;
      if (k == raiseAt) packet_valid = 1'b1;
      tick();
    end
  endtask

  task automatic runFrame(input int dropDviAt);
    logic prevVs;
    fActive = 0; fVPre = 0; fVGuard = 0; fIsland = 0; fReady = 0;
    fHs = 0; fVs = 0; fFs = 0; hsMin = 999; hsMax = -1; vsMinY = 999; vsMaxY = -1;
    vsBadEdge = 0;
    prevVs = vsync;
    for (int i = 0; i < FW * FH; i++) begin
      if (timings == VideoActive)   fActive++;
      if (timings == VideoPreamble) fVPre++;
      if (timings == VideoGuard)    fVGuard++;
      if (isIsland(timings))        fIsland++;
      if (packet_ready)             fReady++;
      if (frame_start)              fFs++;
      if (hsync) begin
        fHs++;
        if (y == 0 && int'(x) < hsMin) hsMin = int'(x);
        if (y == 0 && int'(x) > hsMax) hsMax = int'(x);
      end
      if (vsync) begin
        fVs++;
        if (int'(y) < vsMinY) vsMinY = int'(y);
        if (int'(y) > vsMaxY) vsMaxY = int'(y);
      end
      if (vsync != prevVs && x != 0) vsBadEdge++;
      prevVs = vsync;
      if (i == dropDviAt) dvi_mode = 1'b0;
      tick();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(x), 159);
    chk("rst_y", int'(y), 11);
    chk("rst_timings", int'(timings), int'(Control));
    chk("rst_hsync", int'(hsync), 0);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_ready", int'(packet_ready), 0);
    chk("rst_cycle", int'(packet_cycle), 0);
    chk("rst_index", int'(packet_index), 0);

    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("first_x", int'(x), 0);
    chk("first_y", int'(y), 0);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_timings", int'(timings), int'(VideoActive));

    // Frame 1: no packets offered
    runFrame(-1);
    chk("f1_active", fActive, 320);
    chk("f1_vpre", fVPre, 64);
    chk("f1_vguard", fVGuard, 16);
    chk("f1_island", fIsland, 0);
    chk("f1_ready", fReady, 0);
    chk("f1_frame_start", fFs, 1);
    chk("f1_hs_count", fHs, 96);
    chk("f1_hs_first", hsMin, 135);
    chk("f1_hs_last", hsMax, 142);
    chk("f1_vs_count", fVs, 320);
    chk("f1_vs_first", vsMinY, 9);
    chk("f1_vs_last", vsMaxY, 10);
    chk("f1_vs_edge_x", vsBadEdge, 0);
    chk("f2_wrap_fs", int'(frame_start), 1);
    chk("f2_wrap_xy", int'({x, 4'(y)}), 0);

    // Frame 2 line 0: packet_valid held high, island capped at two packets
    packet_valid = 1'b1;
    recLine(1'b0, -1);
    chk("l0_active", countRange(0, 39, VideoActive), 40);
    chk("l0_ctrl_pre", countRange(40, 51, Control), 12);
    chk("l0_di_pre", countRange(52, 59, DataIslandPreamble), 8);
    chk("l0_lead_guard", countRange(60, 61, DataIslandGuard), 2);
    chk("l0_di_active", countRange(62, 125, DataIslandActive), 64);
    chk("l0_trail_guard", countRange(126, 127, DataIslandGuard), 2);
    chk("l0_ctrl_post", countRange(128, 149, Control), 22);
    chk("l0_vpre", countRange(150, 157, VideoPreamble), 8);
    chk("l0_vguard", countRange(158, 159, VideoGuard), 2);
    chk("l0_ready_count", readyCount(), 2);
    chk("l0_ready_62", int'(rdy[62]), 1);
    chk("l0_ready_94", int'(rdy[94]), 1);
    chk("l0_cycle_62", pcA[62], 0);
    chk("l0_cycle_125", pcA[125], 31);
    chk("l0_index_94", piA[94], 1);

    // Line 1: valid dropped at the first packet_ready -> single packet
    recLine(1'b1, -1);
    chk("l1_di_active", countRange(62, 93, DataIslandActive), 32);
    chk("l1_trail_guard", countRange(94, 95, DataIslandGuard), 2);
    chk("l1_ctrl_post", countRange(96, 149, Control), 54);
    chk("l1_ready_count", readyCount(), 1);

    // Line 2: no packet offered
    recLine(1'b0, -1);
    chk("l2_island", islandCount(), 0);
    chk("l2_ready", readyCount(), 0);

    // Line 3: valid raised after the decision point; island waits for line 4
    recLine(1'b0, 53);
    chk("l3_island", islandCount(), 0);
    recLine(1'b0, -1);
    chk("l4_di_pre", countRange(52, 59, DataIslandPreamble), 8);
    chk("l4_di_active", countRange(62, 125, DataIslandActive), 64);

    // DVI raised mid-frame: current frame still carries islands
    dvi_mode = 1'b1;
    recLine(1'b0, -1);
    chk("l5_hdmi_kept", countRange(62, 125, DataIslandActive), 64);
    waitPos(0, 0, "reach_f3");

    // Frame 3 in DVI mode; dvi_mode dropped partway through
    runFrame(100);
    chk("f3_island", fIsland, 0);
    chk("f3_vpre", fVPre, 0);
    chk("f3_vguard", fVGuard, 0);
    chk("f3_ready", fReady, 0);
    chk("f3_active", fActive, 320);

    // Frame 4: HDMI restored
    recLine(1'b0, -1);
    chk("f4_di_pre", countRange(52, 59, DataIslandPreamble), 8);
    chk("f4_vpre", countRange(150, 157, VideoPreamble), 8);

    // Reset asserted inside an island
    waitPos(70, 1, "reach_island");
    chk("pre_rst_timings", int'(timings), int'(DataIslandActive));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x", int'(x), 159);
    chk("mid_rst_y", int'(y), 11);
    chk("mid_rst_timings", int'(timings), int'(Control));
    chk("mid_rst_ready", int'(packet_ready), 0);
    chk("mid_rst_cycle", int'(packet_cycle), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rerel_xy", int'({x, 4'(y)}), 0);
    chk("rerel_fs", int'(frame_start), 1);
    chk("rerel_timings", int'(timings), int'(VideoActive));

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

`default_nettype wire
